// File: rtl/mem_port_arbiter.sv
// Main-memory front end: fetch and load reads share one memory port with a posted store buffer.
// Define STORE_FWD_EN to forward buffered store data to hazarding loads instead of holding them.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SB_DEPTH     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  st_gnt,
    output logic                  sb_empty,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Handshake: a request is accepted in the cycle where req && gnt are both high; the
    // requester keeps req and its address stable until then. rvalid is a one-cycle pulse.

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]   r_sb_addr [SB_DEPTH];
    logic [DATA_WIDTH-1:0]   r_sb_data [SB_DEPTH];
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;

    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_ld;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_hazard;
    logic [PTR_W-1:0]        w_idx;
    logic                    w_enq;
    logic                    w_drain;
    logic                    w_drain_haz;
    logic                    w_ld_gnt;
    logic                    w_ld_fwd;
    logic                    w_ld_port;
    logic                    w_fetch_gnt;
    logic                    w_read;
    logic                    w_out_v;
    logic                    w_out_ld;

`ifdef STORE_FWD_EN
    logic [READ_LATENCY-1:0] r_tag_fwd;
    logic [DATA_WIDTH-1:0]   r_tag_data [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   w_fwd_data;
`endif

    assign w_full  = (r_count == CNT_W'(SB_DEPTH));
    assign w_empty = (r_count == '0);

    // Walk valid entries oldest to youngest so the last match is the youngest store.
    always_comb begin
        w_hazard = 1'b0;
        w_idx    = r_head;
`ifdef STORE_FWD_EN
        w_fwd_data = '0;
`endif
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_sb_addr[w_idx] == ld_addr)) begin
                w_hazard = 1'b1;
`ifdef STORE_FWD_EN
                w_fwd_data = r_sb_data[w_idx];
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign w_drain_haz = 1'b0;
    assign w_ld_gnt    = ld_req && !w_full;
    assign w_ld_fwd    = w_ld_gnt && w_hazard;
`else
    assign w_drain_haz = ld_req && w_hazard && !w_full;
    assign w_ld_gnt    = ld_req && !w_hazard && !w_full;
    assign w_ld_fwd    = 1'b0;
`endif

    // A pending load always wins the read slot over fetch, even when it is held or forwarded.
    assign w_fetch_gnt = fetch_req && !w_full && !ld_req;
    assign w_ld_port   = w_ld_gnt && !w_ld_fwd;
    assign w_read      = w_ld_port || w_fetch_gnt;
    assign w_drain     = w_full || w_drain_haz || (!w_empty && !w_read);
    assign w_enq       = st_req && !w_full;

    assign fetch_gnt = w_fetch_gnt;
    assign ld_gnt    = w_ld_gnt;
    assign st_gnt    = w_enq;
    assign sb_empty  = w_empty;

    assign mem_re    = w_read;
    assign mem_we    = w_drain;
    assign mem_addr  = w_drain     ? r_sb_addr[r_head] :
                       w_ld_port   ? ld_addr :
                       w_fetch_gnt ? fetch_addr : '0;
    assign mem_wdata = w_drain ? r_sb_data[r_head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload needs no reset: r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_sb_addr[r_tail] <= st_addr;
            r_sb_data[r_tail] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_ld <= '0;
        end else begin
            r_tag_v[0]  <= w_read || w_ld_fwd;
            r_tag_ld[0] <= w_ld_gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_ld[i] <= r_tag_ld[i-1];
            end
        end
    end

`ifdef STORE_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_fwd <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag_data[i] <= '0;
            end
        end else begin
            r_tag_fwd[0]  <= w_ld_fwd;
            r_tag_data[0] <= w_fwd_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_fwd[i]  <= r_tag_fwd[i-1];
                r_tag_data[i] <= r_tag_data[i-1];
            end
        end
    end
`endif

    assign w_out_v  = r_tag_v[READ_LATENCY-1];
    assign w_out_ld = r_tag_ld[READ_LATENCY-1];

    assign fetch_rvalid = w_out_v && !w_out_ld;
    assign ld_rvalid    = w_out_v && w_out_ld;
    assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;

`ifdef STORE_FWD_EN
    assign ld_rdata = !ld_rvalid ? '0 :
                      r_tag_fwd[READ_LATENCY-1] ? r_tag_data[READ_LATENCY-1] : mem_rdata;
`else
    assign ld_rdata = ld_rvalid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (SB_DEPTH=4, READ_LATENCY=2) with a small memory model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SBD = 4;
    localparam int RL  = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req, ld_req, st_req;
    logic [AW-1:0] fetch_addr, ld_addr, st_addr;
    logic [DW-1:0] st_data;
    logic          fetch_gnt, fetch_rvalid, ld_gnt, ld_rvalid, st_gnt, sb_empty;
    logic [DW-1:0] fetch_rdata, ld_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_DEPTH(SBD), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_gnt(st_gnt),
        .sb_empty(sb_empty),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: read data captured at the read edge, presented RL cycles after mem_re.
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge clk) begin
        if (mem_we) mem_arr[int'(mem_addr & 32'hFF)] <= mem_wdata;
        rd_pipe[0] <= mem_re ? mem_arr[int'(mem_addr & 32'hFF)] : 32'hBAD0BAD0;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    typedef struct {
        logic          f_req;
        logic [AW-1:0] f_addr;
        logic          l_req;
        logic [AW-1:0] l_addr;
        logic          s_req;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_data;
        logic [2:0]    e_gnt;
        logic          e_re;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_frv;
        logic [DW-1:0] e_frd;
        logic          e_lrv;
        logic [DW-1:0] e_lrd;
        logic          e_sbe;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic f, input logic [AW-1:0] fa, input logic l, input logic [AW-1:0] la,
                       input logic s, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic [2:0] g, input logic re, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic frv, input logic [DW-1:0] frd,
                       input logic lrv, input logic [DW-1:0] lrd, input logic sbe);
        vec_t v;
        v.f_req = f;  v.f_addr = fa; v.l_req = l; v.l_addr = la;
        v.s_req = s;  v.s_addr = sa; v.s_data = sd;
        v.e_gnt = g;  v.e_re = re; v.e_we = we; v.e_addr = a; v.e_wdata = wd;
        v.e_frv = frv; v.e_frd = frd; v.e_lrv = lrv; v.e_lrd = lrd; v.e_sbe = sbe;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic f, input logic [AW-1:0] fa, input logic l, input logic [AW-1:0] la,
                         input logic s, input logic [AW-1:0] sa, input logic [DW-1:0] sd);
        fetch_req = f; fetch_addr = fa;
        ld_req    = l; ld_addr    = la;
        st_req    = s; st_addr    = sa; st_data = sd;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string n, input logic [2:0] g, input logic re, input logic we,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic frv, input logic [DW-1:0] frd,
                              input logic lrv, input logic [DW-1:0] lrd, input logic sbe);
        check({n, ".gnt{f,l,s}"}, 72'({fetch_gnt, ld_gnt, st_gnt}), 72'(g));
        check({n, ".mem{re,we,addr,wdata}"}, 72'({mem_re, mem_we, mem_addr, mem_wdata}),
              72'({re, we, a, wd}));
        check({n, ".ret{frv,frd,lrv,lrd}"}, 72'({fetch_rvalid, fetch_rdata, ld_rvalid, ld_rdata}),
              72'({frv, frd, lrv, lrd}));
        check({n, ".sb_empty"}, 72'(sb_empty), 72'(sbe));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
        mem_arr[8'h10] <= 32'hDEADBEEF;
        mem_arr[8'h14] <= 32'h11111111;
        mem_arr[8'h18] <= 32'h22222222;
        mem_arr[8'h60] <= 32'h66666666;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_outs("reset", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;

        // f  faddr   l  laddr   s  saddr  sdata   gnt  re we addr   wdata  frv frd           lrv lrd           sbe
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     0, 0,            0, 0,            1);
        add(1, 'h10,  0, 0,      0, 0,     0,      3'b100, 1, 0, 'h10,  0,     0, 0,            0, 0,            1);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     0, 0,            0, 0,            1);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     1, 'hDEADBEEF,   0, 0,            1);
        add(1, 'h14,  1, 'h18,   0, 0,     0,      3'b010, 1, 0, 'h18,  0,     0, 0,            0, 0,            1);
        add(1, 'h14,  0, 0,      0, 0,     0,      3'b100, 1, 0, 'h14,  0,     0, 0,            0, 0,            1);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     0, 0,            1, 'h22222222,   1);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     1, 'h11111111,   0, 0,            1);
        add(1, 'h10,  0, 0,      1, 'h40,  'hA0,   3'b101, 1, 0, 'h10,  0,     0, 0,            0, 0,            1);
        add(1, 'h14,  0, 0,      1, 'h44,  'hA1,   3'b101, 1, 0, 'h14,  0,     0, 0,            0, 0,            0);
        add(1, 'h18,  0, 0,      1, 'h48,  'hA2,   3'b101, 1, 0, 'h18,  0,     1, 'hDEADBEEF,   0, 0,            0);
        add(1, 'h10,  0, 0,      1, 'h4C,  'hA3,   3'b101, 1, 0, 'h10,  0,     1, 'h11111111,   0, 0,            0);
        add(1, 'h14,  0, 0,      1, 'h50,  'hA4,   3'b000, 0, 1, 'h40,  'hA0,  1, 'h22222222,   0, 0,            0);
        add(1, 'h14,  0, 0,      0, 0,     0,      3'b100, 1, 0, 'h14,  0,     1, 'hDEADBEEF,   0, 0,            0);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 1, 'h44,  'hA1,  0, 0,            0, 0,            0);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 1, 'h48,  'hA2,  1, 'h11111111,   0, 0,            0);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 1, 'h4C,  'hA3,  0, 0,            0, 0,            0);
        add(1, 'h40,  0, 0,      0, 0,     0,      3'b100, 1, 0, 'h40,  0,     0, 0,            0, 0,            1);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     0, 0,            0, 0,            1);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     1, 'hA0,         0, 0,            1);
        add(0, 0,     1, 'h60,   1, 'h60,  'h77,   3'b011, 1, 0, 'h60,  0,     0, 0,            0, 0,            1);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 1, 'h60,  'h77,  0, 0,            0, 0,            0);
        add(0, 0,     0, 0,      0, 0,     0,      3'b000, 0, 0, 0,     0,     0, 0,            1, 'h66666666,   1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req, vecs[i].l_addr,
                  vecs[i].s_req, vecs[i].s_addr, vecs[i].s_data);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_re, vecs[i].e_we,
                       vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_frv, vecs[i].e_frd,
                       vecs[i].e_lrv, vecs[i].e_lrd, vecs[i].e_sbe);
        end

        // Store 0x55 to 0x20, then a load of 0x20 hits the buffered entry.
        @(negedge clk); drive(0, 0, 0, 0, 1, 'h20, 'h55); #1;
        check_outs("haz_st", 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 1, 'h20, 0, 0, 0); #1;
`ifdef STORE_FWD_EN
        check_outs("haz_fwd", 3'b010, 0, 1, 'h20, 'h55, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check_outs("haz_idle", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        check_outs("haz_ret", 3'b000, 0, 0, 0, 0, 0, 0, 1, 'h55, 1);
`else
        check_outs("haz_hold", 3'b000, 0, 1, 'h20, 'h55, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        check_outs("haz_gnt", 3'b010, 1, 0, 'h20, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
        check_outs("haz_wait", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        check_outs("haz_ret", 3'b000, 0, 0, 0, 0, 0, 0, 1, 'h55, 1);
`endif

        // Reset with two fetches in flight and a buffered store.
        @(negedge clk); drive(1, 'h10, 0, 0, 0, 0, 0); #1;
        check_outs("rst_f0", 3'b100, 1, 0, 'h10, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(1, 'h14, 0, 0, 1, 'h70, 'h99); #1;
        check_outs("rst_f1", 3'b101, 1, 0, 'h14, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0; #1;
        check_outs("rst_mid", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        check_outs("rst_hold", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check_outs($sformatf("rst_post%0d", i), 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
